serial_add_seq: RTL and testbench
=================================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair and carry-in presented.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 op_a  input  WIDTH  first operand.
REQ-007 op_b  input  WIDTH  second operand.
REQ-008 cin  input  1  initial carry-in.
REQ-009 add_a  output  1  a-input bit driven to the external 1-bit adder stage.
REQ-010 add_b  output  1  b-input bit driven to the external 1-bit adder stage.
REQ-011 add_ci  output  1  carry-in bit driven to the external 1-bit adder stage.
REQ-012 add_sum  input  1  sum bit returned by the adder stage; purely combinational from add_a/add_b/add_ci.
REQ-013 add_co  input  1  carry-out bit returned by the adder stage.
REQ-014 out_valid  output  1  result and cout valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 result  output  WIDTH  accumulated sum.
REQ-017 cout  output  1  final carry-out.
REQ-018 busy  output  1  high while in SHIFT.

Function
REQ-019 The block SHALL implement states IDLE, SHIFT and DONE, with all transitions taken on rising clk.
REQ-020 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 otherwise.
REQ-021 An accept (in_valid & in_ready) SHALL load op_a/op_b into shift registers, load cin into the carry register, clear the bit counter and result, and enter SHIFT.
REQ-022 In SHIFT, add_a/add_b SHALL be bit 0 of the a/b shift registers and add_ci SHALL equal the carry register, all driven directly from registers.
REQ-023 Each SHIFT cycle SHALL sample add_sum into result MSB with result shifted right, carry <= add_co, shift a/b right by one, and increment the counter.
REQ-024 After exactly WIDTH SHIFT cycles the block SHALL enter DONE with result = LSB-first accumulated sum and cout = final carry.
REQ-025 Accept-to-out_valid latency SHALL be WIDTH+1 cycles (accept edge, then WIDTH shift edges).
REQ-026 In IDLE and DONE, add_a, add_b and add_ci SHALL be 0.
REQ-027 out_valid SHALL be 1 only in DONE; result and cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 In DONE with out_ready=1: if in_valid=1, the block SHALL accept the new operands and enter SHIFT (back-to-back); otherwise it SHALL enter IDLE.
REQ-029 in_valid during SHIFT SHALL be ignored and SHALL leave no state change.
REQ-030 result + cout<<WIDTH SHALL equal op_a + op_b + cin modulo 2^(WIDTH+1).
REQ-031 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-032 While rst=1, the block SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, cout=0, add_a=add_b=add_ci=0, and counter/shift/carry registers to 0.
REQ-033 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no out_valid pulse, and the first accept after deassertion SHALL behave as from power-up.

Verification
REQ-034 WIDTH=8, op_a=0x05, op_b=0x03, cin=0, out_ready=1 -> out_valid 9 cycles after accept, result=0x08, cout=0, busy high for exactly 8 cycles.
REQ-035 op_a=0xFF, op_b=0x01, cin=0 -> result=0x00, cout=1; op_a=0xFF, op_b=0xFF, cin=1 -> result=0xFF, cout=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/cout unchanged, in_ready=0, in_valid ignored throughout.
REQ-037 Back-to-back: in DONE with out_ready=1 and in_valid=1 (0x10+0x20) -> new accept same edge, next out_valid result=0x30 after 8 further SHIFT cycles.
REQ-038 Assert rst asynchronously at SHIFT bit 4 -> outputs drop to reset values before the next edge; a subsequent 0x7F+0x01 yields result=0x80, cout=0.
REQ-039 Random self-check: 1000 random op_a/op_b/cin with random out_ready stalls, each compared against the REQ-030 reference; add_a/add_b/add_ci checked 0 outside SHIFT.

Source files
------------

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer.
// Feeds operand bits LSB-first to an external 1-bit full-adder stage and
// collects the returned sum bits into the result register.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for an operand pair; adder inputs held at 0
// SHIFT | one bit per cycle through the external adder stage
// DONE  | result/cout valid, held until the consumer takes them
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
    input  logic             add_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             accept;
    logic             last_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == LAST_BIT);

    // The shift registers drain to zero and the carry is cleared on the last
    // bit, so the adder inputs are pure register outputs and are already 0
    // whenever the block is not shifting.
    assign add_a  = a_sh[0];
    assign add_b  = b_sh[0];
    assign add_ci = carry_q;
    assign result = res_q;
    assign cout   = cout_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = accept ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            SHIFT:   busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath: load on accept, otherwise shift one bit per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            res_q   <= '0;
            carry_q <= cin;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (state == SHIFT) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_q   <= {add_sum, res_q[WIDTH-1:1]};
            carry_q <= last_bit ? 1'b0 : add_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last_bit) cout_q <= add_co;
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and random checks of the serial adder sequencer
// with a behavioural full-adder stage closing the loop.
module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             add_a;
    logic             add_b;
    logic             add_ci;
    logic             add_sum;
    logic             add_co;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_sum   (add_sum),
        .add_co    (add_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
    );

    // External 1-bit full adder.
    assign add_sum = add_a ^ add_b ^ add_ci;
    assign add_co  = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; stall = cycles out_ready stays low after out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input int stall, output logic [7:0] r, output logic c,
                          output int lat, output int bcnt, output int stray);
        lat = 0; bcnt = 0; stray = 0;
        op_a = a; op_b = b; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            else if (add_a | add_b | add_ci) stray++;
            tick;
            lat++;
        end
        repeat (stall) begin
            if (add_a | add_b | add_ci) stray++;
            tick;
        end
        if (add_a | add_b | add_ci) stray++;
        r = result; c = cout;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        if (add_a | add_b | add_ci) stray++;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%0b exp=0", cout); end
        checks++; if ({add_a, add_b, add_ci} !== 3'b000) begin failures++; $display("FAIL reset_add got=%b exp=000", {add_a, add_b, add_ci}); end
        #10;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [7:0] r; logic c; int lat, bcnt, stray;
        run_op(8'h05, 8'h03, 1'b0, 0, r, c, lat, bcnt, stray);
        checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (bcnt !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bcnt); end
        checks++; if (r !== 8'h08) begin failures++; $display("FAIL basic_result got=%h exp=08", r); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%0b exp=0", c); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL basic_add_idle got=%0d exp=0", stray); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_back_idle got=%0b%0b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_carry;
        logic [7:0] r; logic c; int lat, bcnt, stray;
        run_op(8'hFF, 8'h01, 1'b0, 1, r, c, lat, bcnt, stray);
        checks++; if ({c, r} !== 9'h100) begin failures++; $display("FAIL carry_ff_01 got=%0b_%h exp=1_00", c, r); end
        run_op(8'hFF, 8'hFF, 1'b1, 2, r, c, lat, bcnt, stray);
        checks++; if ({c, r} !== 9'h1FF) begin failures++; $display("FAIL carry_ff_ff_1 got=%0b_%h exp=1_ff", c, r); end
        checks++; if (stray !== 0) begin failures++; $display("FAIL carry_add_idle got=%0d exp=0", stray); end
    endtask

    task automatic test_backpressure;
        int n;
        // 0x5A + 0x3C + 1 = 0x97, no carry out
        op_a = 8'h5A; op_b = 8'h3C; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin tick; n++; end
        checks++; if (n !== 9) begin failures++; $display("FAIL bp_latency got=%0d exp=9", n); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op_a = 8'h11; op_b = 8'h22; cin = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
            tick;
            checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_hold_state cyc=%0d got=%0b%0b exp=10", i, out_valid, busy); end
            checks++; if ({cout, result} !== 9'h097) begin failures++; $display("FAIL bp_hold_result cyc=%0d got=%0b_%h exp=0_97", i, cout, result); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b%0b%0b exp=010", out_valid, in_ready, busy); end
    endtask

    task automatic test_ignore_in_shift;
        int n;
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
        n = 1;
        while (!out_valid && n < 40) begin tick; n++; end
        in_valid = 1'b0;
        checks++; if (n !== 9) begin failures++; $display("FAIL ignore_latency got=%0d exp=9", n); end
        checks++; if ({cout, result} !== 9'h046) begin failures++; $display("FAIL ignore_result got=%0b_%h exp=0_46", cout, result); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        op_a = 8'h01; op_b = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin tick; n++; end
        checks++; if (result !== 8'h03) begin failures++; $display("FAIL b2b_first got=%h exp=03", result); end
        op_a = 8'h10; op_b = 8'h20; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_reaccept got=%0b%0b exp=10", busy, out_valid); end
        n = 1;
        while (!out_valid && n < 40) begin tick; n++; end
        checks++; if (n !== 9) begin failures++; $display("FAIL b2b_latency got=%0d exp=9", n); end
        checks++; if ({cout, result} !== 9'h030) begin failures++; $display("FAIL b2b_result got=%0b_%h exp=0_30", cout, result); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] r; logic c; int lat, bcnt, stray, ov;
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%0b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got=%0b%0b%0b exp=010", busy, in_ready, out_valid); end
        checks++; if ({cout, result} !== 9'h000) begin failures++; $display("FAIL rstmid_result got=%0b_%h exp=0_00", cout, result); end
        checks++; if ({add_a, add_b, add_ci} !== 3'b000) begin failures++; $display("FAIL rstmid_add got=%b exp=000", {add_a, add_b, add_ci}); end
        #3 rst = 1'b0;
        ov = 0;
        repeat (12) begin tick; if (out_valid) ov++; end
        checks++; if (ov !== 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", ov); end
        run_op(8'h7F, 8'h01, 1'b0, 0, r, c, lat, bcnt, stray);
        checks++; if (lat !== 9) begin failures++; $display("FAIL rstmid_after_latency got=%0d exp=9", lat); end
        checks++; if ({c, r} !== 9'h080) begin failures++; $display("FAIL rstmid_after_result got=%0b_%h exp=0_80", c, r); end
    endtask

    task automatic test_random;
        logic [7:0] a, b, r; logic ci, c; logic [8:0] exp9;
        int lat, bcnt, stray;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            exp9 = {1'b0, a} + {1'b0, b} + {8'h00, ci};
            run_op(a, b, ci, int'($urandom_range(0, 3)), r, c, lat, bcnt, stray);
            checks++; if ({c, r} !== exp9) begin failures++; $display("FAIL rand_sum i=%0d a=%h b=%h ci=%0b got=%0b_%h exp=%0b_%h", i, a, b, ci, c, r, exp9[8], exp9[7:0]); end
            checks++; if (lat !== 9 || bcnt !== 8) begin failures++; $display("FAIL rand_timing i=%0d got=%0d/%0d exp=9/8", i, lat, bcnt); end
            checks++; if (stray !== 0) begin failures++; $display("FAIL rand_add_idle i=%0d got=%0d exp=0", i, stray); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_ignore_in_shift;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
